// File: rtl/rca_sweep_pkg.sv
//============================================================================
// Module      : rca_sweep_pkg
// Description : Shared types and constants for the ripple-carry adder sweep
//               controller: FSM state encoding and error-counter sizing.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package rca_sweep_pkg;

    // Sweep controller states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int             ERR_W   = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = 16'hFFFF;

endpackage : rca_sweep_pkg

`default_nettype wire

// File: rtl/rca_sweep_gen.sv
//============================================================================
// Module      : rca_sweep_gen
// Description : Exhaustive operand vector counter {cin, a, b}. b is the
//               fastest-moving field, a the next, cin (when enabled) the
//               outermost. Flags the final vector (all ones).
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   RCA_SWEEP_CIN_EN  defined   -> counter carries an extra cin bit (MSB)
//                     undefined -> no cin bit; cin_o tied to 0
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   clr_i   in   clear counter to vector 0 (priority over inc_i)
//   inc_i   in   advance to next vector
//   a_o     out  operand A field   [WIDTH-1:0]
//   b_o     out  operand B field   [WIDTH-1:0]
//   cin_o   out  carry-in field
//   last_o  out  current vector is the last of the sweep
//============================================================================
`default_nettype none

module rca_sweep_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             cin_o,
    output logic             last_o
);

`ifdef RCA_SWEEP_CIN_EN
    localparam int CNT_W = 2*WIDTH + 1;
`else
    localparam int CNT_W = 2*WIDTH;
`endif

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign b_o    = cnt_q[WIDTH-1:0];
    assign a_o    = cnt_q[2*WIDTH-1:WIDTH];
    // Last vector is a = b = all ones at the final cin value: the whole
    // counter is all ones regardless of whether the cin bit exists.
    assign last_o = &cnt_q;

`ifdef RCA_SWEEP_CIN_EN
    assign cin_o  = cnt_q[2*WIDTH];
`else
    assign cin_o  = 1'b0;
`endif

endmodule : rca_sweep_gen

`default_nettype wire

// File: rtl/rca_sweep_ctrl.sv
//============================================================================
// Module      : rca_sweep_ctrl
// Description : Exhaustive self-test sweep for an external WIDTH-bit
//               ripple-carry adder. Each vector is driven for one settle
//               cycle (DRIVE) and checked the following cycle (CHECK).
//               Mismatches are counted (saturating) and the first failing
//               vector is captured.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   RCA_SWEEP_CIN_EN  defined -> carry-in swept 0 then 1 (outermost index)
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   begin a sweep (sampled in IDLE/DONE only)
//   a_o/b_o   out  operands to the adder           [WIDTH-1:0]
//   cin_o     out  carry-in to the adder
//   sum_i     in   adder sum                       [WIDTH-1:0]
//   cout_i    in   adder carry-out
//   busy      out  sweep in progress (DRIVE/CHECK)
//   done      out  sweep finished (level)
//   pass      out  done with zero mismatches
//   err_cnt   out  saturating mismatch count      [15:0]
//   fail_a/b  out  operands of first mismatch      [WIDTH-1:0]
//   fail_cin  out  carry-in of first mismatch
//============================================================================
`default_nettype none

module rca_sweep_ctrl
    import rca_sweep_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             cin_o,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin
);

    state_e state_q;
    state_e state_d;

    logic vec_clr;
    logic vec_inc;
    logic vec_last;
    logic chk_en;

    logic [WIDTH:0] exp_sum;
    logic           mismatch;

    logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;
    logic [WIDTH-1:0] fail_a_q,   fail_a_d;
    logic [WIDTH-1:0] fail_b_q,   fail_b_d;
    logic             fail_cin_q, fail_cin_d;

    rca_sweep_gen #(
        .WIDTH (WIDTH)
    ) u_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (vec_clr),
        .inc_i  (vec_inc),
        .a_o    (a_o),
        .b_o    (b_o),
        .cin_o  (cin_o),
        .last_o (vec_last)
    );

    //------------------------------------------------------------------------
    // FSM
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_clr = 1'b0;
        vec_inc = 1'b0;
        chk_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    vec_clr = 1'b1;
                end
            end
            ST_DRIVE: begin
                // Operands were registered on the previous edge; this cycle
                // gives the ripple chain time to settle before sampling.
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                chk_en = 1'b1;
                if (vec_last) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                    vec_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Checker and first-failure capture
    //------------------------------------------------------------------------
    assign exp_sum  = {1'b0, a_o} + {1'b0, b_o} + {{WIDTH{1'b0}}, cin_o};
    assign mismatch = chk_en && ({cout_i, sum_i} != exp_sum);

    always_comb begin
        err_cnt_d  = err_cnt_q;
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        fail_cin_d = fail_cin_q;
        if (vec_clr) begin
            err_cnt_d  = '0;
            fail_a_d   = '0;
            fail_b_d   = '0;
            fail_cin_d = 1'b0;
        end else if (mismatch) begin
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            // Only the first failing vector is kept.
            if (err_cnt_q == '0) begin
                fail_a_d   = a_o;
                fail_b_d   = b_o;
                fail_cin_d = cin_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q  <= '0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_cin_q <= 1'b0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
            fail_cin_q <= fail_cin_d;
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    assign busy     = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    assign done     = (state_q == ST_DONE);
    assign pass     = (state_q == ST_DONE) && (err_cnt_q == '0);
    assign err_cnt  = err_cnt_q;
    assign fail_a   = fail_a_q;
    assign fail_b   = fail_b_q;
    assign fail_cin = fail_cin_q;

endmodule : rca_sweep_ctrl

`default_nettype wire

// File: tb/tb_rca_sweep_ctrl.sv
//============================================================================
// Module      : tb_rca_sweep_ctrl
// Description : Self-checking bench for rca_sweep_ctrl at WIDTH=2 with a
//               behavioural adder that can be faulted (sum bit0 stuck at 0,
//               or carry-out forced to 0). Honours RCA_SWEEP_CIN_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_rca_sweep_ctrl;

    localparam int W = 2;
`ifdef RCA_SWEEP_CIN_EN
    localparam int NV = 1 << (2*W + 1);
`else
    localparam int NV = 1 << (2*W);
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_o, b_o, sum_i;
    logic         cin_o, cout_i;
    logic         busy, done, pass;
    logic [15:0]  err_cnt;
    logic [W-1:0] fail_a, fail_b;
    logic         fail_cin;

    int fault_mode;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0]  err;
        logic         pass;
        logic [W-1:0] fa;
        logic [W-1:0] fb;
        logic         fc;
    } res_t;

    res_t         res_q[$];
    logic [2*W:0] vec_q[$];
    logic [2*W:0] last_vec;

    always #5 clk = ~clk;

    rca_sweep_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_o      (a_o),
        .b_o      (b_o),
        .cin_o    (cin_o),
        .sum_i    (sum_i),
        .cout_i   (cout_i),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_a   (fail_a),
        .fail_b   (fail_b),
        .fail_cin (fail_cin)
    );

    // Behavioural adder with optional fault: 1 = sum bit0 stuck 0, 2 = cout 0.
    function automatic logic [W:0] adder_model(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic c, input int f);
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        if (f == 1) r[0] = 1'b0;
        else if (f == 2) r[W] = 1'b0;
        return r;
    endfunction

    always_comb {cout_i, sum_i} = adder_model(a_o, b_o, cin_o, fault_mode);

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push the expected vector stream (each vector occupies DRIVE+CHECK)
    // and the expected end-of-sweep result for the given adder fault.
    task automatic push_expected(input int f);
        res_t r;
        r.err = '0; r.pass = 1'b0; r.fa = '0; r.fb = '0; r.fc = 1'b0;
        for (int n = 0; n < NV; n++) begin
            logic [W-1:0] a, b;
            logic         c;
            logic [W:0]   good;
            b    = n[W-1:0];
            a    = n[2*W-1:W];
            c    = (NV > (1 << (2*W))) ? n[2*W] : 1'b0;
            good = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            if (adder_model(a, b, c, f) != good) begin
                if (r.err == 16'd0) begin
                    r.fa = a; r.fb = b; r.fc = c;
                end
                r.err = r.err + 16'd1;
            end
            vec_q.push_back({c, a, b});
            vec_q.push_back({c, a, b});
        end
        r.pass = (r.err == 16'd0);
        res_q.push_back(r);
    endtask

    // Called at a negedge inside a sweep, with 'remain' busy cycles left.
    task automatic wait_done_check(input int remain);
        int cyc = 0;
        while (cyc < remain + 4 && !done) begin
            check_eq("busy", 32'(busy), 32'd1);
            check_eq("pass_while_busy", 32'(pass), 32'd0);
            if (vec_q.size() > 0) begin
                last_vec = vec_q.pop_front();
                check_eq("ops", 32'({cin_o, a_o, b_o}), 32'(last_vec));
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("done_latency", 32'(cyc), 32'(remain));
        check_eq("done", 32'(done), 32'd1);
        check_eq("busy_in_done", 32'(busy), 32'd0);
        check_eq("ops_held", 32'({cin_o, a_o, b_o}), 32'(last_vec));
        if (res_q.size() > 0) begin
            res_t r;
            r = res_q.pop_front();
            check_eq("err_cnt", 32'(err_cnt), 32'(r.err));
            check_eq("pass", 32'(pass), 32'(r.pass));
            check_eq("fail_a", 32'(fail_a), 32'(r.fa));
            check_eq("fail_b", 32'(fail_b), 32'(r.fb));
            check_eq("fail_cin", 32'(fail_cin), 32'(r.fc));
        end else begin
            check_eq("result_queue_nonempty", 32'd0, 32'd1);
        end
        vec_q.delete();
    endtask

    task automatic kick(input int f);
        fault_mode = f;
        push_expected(f);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_pass"}, 32'(pass), 32'd0);
        check_eq({tag, "_err"}, 32'(err_cnt), 32'd0);
        check_eq({tag, "_ops"}, 32'({cin_o, a_o, b_o}), 32'd0);
        check_eq({tag, "_fail"}, 32'({fail_cin, fail_a, fail_b}), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        fault_mode = 0;
        last_vec   = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle");

        // Correct adder; DONE holds its outputs.
        kick(0);
        wait_done_check(2*NV);
        repeat (3) @(negedge clk);
        check_eq("done_hold", 32'(done), 32'd1);
        check_eq("ops_hold_3", 32'({a_o, b_o}), 32'({W{2'b11}}));

        // Faulted adders, each started from DONE.
        kick(1);
        wait_done_check(2*NV);
`ifndef RCA_SWEEP_CIN_EN
        check_eq("sum0_err_const", 32'(err_cnt), 32'd8);
`endif
        kick(2);
        wait_done_check(2*NV);

        // Reset mid-sweep with start asserted during reset.
        kick(0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        check_idle("midreset");
        vec_q.delete();
        res_q.delete();
        @(negedge clk);
        check_idle("post_reset");
        kick(0);
        wait_done_check(2*NV);

        // start held through a sweep: restart only in the first DONE cycle.
        fault_mode = 1;
        push_expected(1);
        start = 1'b1;
        @(negedge clk);
        wait_done_check(2*NV);
        push_expected(1);
        @(negedge clk);
        start = 1'b0;
        check_eq("restart_busy", 32'(busy), 32'd1);
        check_eq("restart_err_clr", 32'(err_cnt), 32'd0);
        last_vec = vec_q.pop_front();
        check_eq("restart_ops", 32'({cin_o, a_o, b_o}), 32'(last_vec));
        @(negedge clk);
        wait_done_check(2*NV - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rca_sweep_ctrl

`default_nettype wire
